// File: rtl/filter_1.sv
// filter_1: windowed pixel filter with valid/ready handshakes, per-session configuration and hit count.
// Defining FILTER_STAT_EN builds the saturating hit accumulator driven onto stat_hits.
module filter_1 #(
  parameter  int PIXEL_SIZE = 3,
  parameter  int PIXEL_NUM  = 4,
  localparam int W          = 1 << PIXEL_SIZE,
  localparam int C          = $clog2(PIXEL_NUM + 1)
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         enable,
  input  logic         clear,
  input  logic [2:0]   mode,
  input  logic [W-1:0] omega,
  input  logic [W-1:0] epsilon,
  input  logic [W-1:0] pixel [PIXEL_NUM],
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] result [PIXEL_NUM],
  output logic [C-1:0] hit_count,
  output logic [W-1:0] round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [15:0]  stat_hits
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     mode_q, mode_d;
  logic [W-1:0]   omega_q, omega_d;
  logic [W-1:0]   eps_q, eps_d;
  logic [W-1:0]   r_q, r_d;
  logic [W-1:0]   result_q [PIXEL_NUM];
  logic [W-1:0]   result_d [PIXEL_NUM];
  logic [C-1:0]   hit_q, hit_d;
  logic [W-1:0]   round_q, round_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_s;
  logic           accept_s;
  logic [PIXEL_NUM-1:0] in_win_s;
  logic [W-1:0]   filt_s [PIXEL_NUM];
  logic [C-1:0]   cnt_s;

  // Window test and mode-selected value for every pixel of the incoming beat
  always_comb begin
    cnt_s    = {C{1'b0}};
    in_win_s = {PIXEL_NUM{1'b0}};
    for (int i = 0; i < PIXEL_NUM; i++) begin
      filt_s[i]   = {W{1'b0}};
      // An inverted or equal window yields no hits without a separate check
      in_win_s[i] = (omega_q < pixel[i]) && (pixel[i] < eps_q);
      case (mode_q)
        3'd0:    filt_s[i] = in_win_s[i] ? {W{1'b1}} : {W{1'b0}};
        3'd1:    filt_s[i] = in_win_s[i] ? r_q : {W{1'b0}};
        3'd2:    filt_s[i] = in_win_s[i] ? pixel[i] : {W{1'b0}};
        3'd3:    filt_s[i] = in_win_s[i] ?
                             W'(32'(r_q) * 32'(PIXEL_NUM) + 32'(PIXEL_NUM - 1 - i)) : {W{1'b0}};
        3'd4:    filt_s[i] = in_win_s[i] ? pixel[i] - omega_q : {W{1'b0}};
        3'd5:    filt_s[i] = in_win_s[i] ? eps_q - pixel[i] : {W{1'b0}};
        3'd6:    filt_s[i] = in_win_s[i] ? {W{1'b0}} : pixel[i];
        default: filt_s[i] = {W{1'b0}};
      endcase
      cnt_s = cnt_s + C'(in_win_s[i]);
    end
  end

  // Session FSM: configuration latch, handshakes and output beat register
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    omega_d     = omega_q;
    eps_d       = eps_q;
    r_d         = r_q;
    result_d    = result_q;
    hit_d       = hit_q;
    round_d     = round_q;
    out_valid_d = out_valid_q;
    in_ready_s  = 1'b0;
    accept_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          mode_d  = mode;
          omega_d = omega;
          eps_d   = epsilon;
          r_d     = {W{1'b0}};
          for (int i = 0; i < PIXEL_NUM; i++) begin
            result_d[i] = {W{1'b0}};
          end
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        in_ready_s = !clear && (!out_valid_q || out_ready);
        accept_s   = in_ready_s && in_valid;
        if (clear) begin
          if (out_valid_q && !out_ready) begin
            state_d = S_DRAIN;
          end else begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
        end else if (accept_s) begin
          result_d    = filt_s;
          hit_d       = cnt_s;
          round_d     = r_q;
          out_valid_d = 1'b1;
          r_d         = r_q + W'(1'b1);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= S_IDLE;
      mode_q      <= 3'd0;
      omega_q     <= {W{1'b0}};
      eps_q       <= {W{1'b0}};
      r_q         <= {W{1'b0}};
      hit_q       <= {C{1'b0}};
      round_q     <= {W{1'b0}};
      out_valid_q <= 1'b0;
      for (int i = 0; i < PIXEL_NUM; i++) begin
        result_q[i] <= {W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      omega_q     <= omega_d;
      eps_q       <= eps_d;
      r_q         <= r_d;
      hit_q       <= hit_d;
      round_q     <= round_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

`ifdef FILTER_STAT_EN
  logic [15:0] stat_q, stat_d;
  logic [16:0] stat_sum_s;

  // Saturating hit accumulator, restarted at each session start
  always_comb begin
    stat_sum_s = {1'b0, stat_q} + 17'(cnt_s);
    if (state_q == S_IDLE && enable) begin
      stat_d = 16'h0000;
    end else if (accept_s) begin
      stat_d = stat_sum_s[16] ? 16'hFFFF : stat_sum_s[15:0];
    end else begin
      stat_d = stat_q;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      stat_q <= 16'h0000;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_hits = stat_q;
`else
  assign stat_hits = 16'h0000;
`endif

  assign in_ready  = in_ready_s;
  assign result    = result_q;
  assign hit_count = hit_q;
  assign round     = round_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_filter_1.sv
// Randomised scoreboard bench for filter_1 (PIXEL_SIZE=3, PIXEL_NUM=4).
module tb_filter_1;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  hc;
    logic [7:0]  rnd;
  } exp_t;

  logic        clk = 1'b0;
  logic        areset;
  logic        enable, clear, in_valid, out_ready;
  logic [2:0]  mode;
  logic [7:0]  omega, epsilon;
  logic [7:0]  pixel [4];
  logic        in_ready, out_valid, busy;
  logic [7:0]  result [4];
  logic [2:0]  hit_count;
  logic [7:0]  round;
  logic [15:0] stat_hits;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  int   or_mode = 2;
  bit   mon_en = 1'b0;
  int   cur_mode, cur_om, cur_ep, cur_r;
  int   stat_exp = 0;

  filter_1 dut (
    .clk(clk), .areset(areset), .enable(enable), .clear(clear), .mode(mode),
    .omega(omega), .epsilon(epsilon), .pixel(pixel), .in_valid(in_valid),
    .in_ready(in_ready), .result(result), .hit_count(hit_count), .round(round),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .stat_hits(stat_hits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] res_w();
    return {result[3], result[2], result[1], result[0]};
  endfunction

  // Reference: apply the window rules to each pixel with plain integer arithmetic
  function automatic exp_t model(input int m, om, ep, r, input logic [31:0] px);
    exp_t e;
    int   p, v, hits;
    bit   in_w;
    hits  = 0;
    e.res = 32'h0;
    for (int i = 0; i < 4; i++) begin
      p    = int'(px[8*i +: 8]);
      in_w = (p > om) && (p < ep);
      if (in_w) hits++;
      case (m)
        0: v = in_w ? 255 : 0;
        1: v = in_w ? r : 0;
        2: v = in_w ? p : 0;
        3: v = in_w ? (r * 4 + 3 - i) % 256 : 0;
        4: v = in_w ? (p - om) & 255 : 0;
        5: v = in_w ? (ep - p) & 255 : 0;
        6: v = in_w ? 0 : p;
        default: v = 0;
      endcase
      e.res[8*i +: 8] = v[7:0];
    end
    e.hc  = hits[2:0];
    e.rnd = r[7:0];
    return e;
  endfunction

  task automatic set_px(input logic [31:0] px);
    for (int i = 0; i < 4; i++) pixel[i] = px[8*i +: 8];
  endtask

  task automatic scramble_cfg();
    mode    = 3'($urandom_range(0, 7));
    omega   = 8'($urandom_range(0, 255));
    epsilon = 8'($urandom_range(0, 255));
    enable  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      set_px($urandom());
      @(posedge clk); #1;
    end
  endtask

  task automatic start_session(input int m, input int om, input int ep);
    mode = 3'(m); omega = 8'(om); epsilon = 8'(ep); enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    cur_mode = m; cur_om = om; cur_ep = ep; cur_r = 0;
    stat_exp = 0;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_result_clear", res_w(), 0);
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [31:0] px, input bit use_c, input exp_t ce, output int waits);
    exp_t e;
    waits    = 0;
    in_valid = 1'b1;
    set_px(px);
    scramble_cfg();
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e = use_c ? ce : model(cur_mode, cur_om, cur_ep, cur_r, px);
        q.push_back(e);
        cur_r = (cur_r + 1) % 256;
`ifdef FILTER_STAT_EN
        stat_exp = (stat_exp + int'(e.hc) > 65535) ? 65535 : stat_exp + int'(e.hc);
`endif
        break;
      end
      waits++;
      if (waits > 200) begin
        chk("accept_timeout", waits, 0);
        break;
      end
      @(posedge clk); #1;
      scramble_cfg();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    enable   = 1'b0;
  endtask

  task automatic end_session();
    bit drain;
    int n, saved;
    clear = 1'b1;
    @(negedge clk);
    drain = (q.size() > 0) && !out_ready;
    @(posedge clk); #1;
    clear = 1'b0;
    n     = 0;
    saved = or_mode;
    while (drain) begin
      @(negedge clk);
      chk("drain_busy", busy, 1);
      if (out_ready) drain = 1'b0;
      else if (n >= 1) or_mode = 1;
      n++;
      if (n > 100) begin
        chk("drain_timeout", n, 0);
        drain = 1'b0;
      end
      @(posedge clk); #1;
    end
    or_mode = saved;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("queue_drained", q.size(), 0);
    chk("stat_hits", stat_hits, 16'(stat_exp));
    @(posedge clk); #1;
  endtask

  // Downstream back-pressure
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = ($urandom_range(0, 99) < 65);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pop and compare on every output transfer, check holds while stalled
  initial begin
    bit   stalled;
    exp_t snap, e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_outputs", {res_w(), hit_count, round}, snap);
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = q.pop_front();
            chk("result", res_w(), e.res);
            chk("hit_count", hit_count, e.hc);
            chk("round", round, e.rnd);
          end
        end else begin
          chk("stall_in_ready", in_ready, 0);
          snap    = {res_w(), hit_count, round};
          stalled = 1'b1;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   w, nb, om, ep, tmp;
    logic [31:0] px;
    areset = 1'b0; enable = 1'b0; clear = 1'b0; in_valid = 1'b0;
    mode = 3'd0; omega = 8'd0; epsilon = 8'd0;
    set_px(32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", res_w(), 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_round", round, 0);
    chk("rst_stat", stat_hits, 0);
    @(posedge clk); #1;
    areset = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Mode 0 basic window
    or_mode = 1;
    start_session(0, 10, 200);
    send_beat(pk(5, 50, 199, 200), 1'b1, '{res: pk(0, 255, 255, 0), hc: 3'd2, rnd: 8'd0}, w);
    end_session();

    // Mode 3 back-to-back with no bubbles
    start_session(3, 10, 200);
    for (int k = 0; k < 3; k++) begin
      send_beat(pk(50, 50, 50, 50), 1'b1,
                '{res: pk(8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)), hc: 3'd4, rnd: 8'(k)}, w);
      chk("no_bubble", w, 0);
    end
    end_session();

    // Modes 4 and 6 on the same beat
    start_session(4, 10, 200);
    send_beat(pk(11, 100, 9, 255), 1'b1, '{res: pk(1, 90, 0, 0), hc: 3'd2, rnd: 8'd0}, w);
    end_session();
    start_session(6, 10, 200);
    send_beat(pk(11, 100, 9, 255), 1'b1, '{res: pk(0, 0, 9, 255), hc: 3'd2, rnd: 8'd0}, w);
    end_session();

    // Stall, then clear while stalled goes through DRAIN
    or_mode = 2;
    start_session(2, 10, 200);
    send_beat($urandom(), 1'b0, '0, w);
    idle(3);
    end_session();

    // Empty window
    or_mode = 0;
    start_session(2, 200, 10);
    for (int k = 0; k < 5; k++) begin
      send_beat($urandom(), 1'b1, '{res: 32'h0, hc: 3'd0, rnd: 8'(k)}, w);
      idle($urandom_range(0, 1));
    end
    end_session();

    // 300 full-hit beats: round counter wraps, stat accumulates
    or_mode = 1;
    start_session(1, 0, 255);
    for (int k = 0; k < 300; k++) begin
      px = pk(8'($urandom_range(1, 254)), 8'($urandom_range(1, 254)),
              8'($urandom_range(1, 254)), 8'($urandom_range(1, 254)));
      send_beat(px, 1'b0, '0, w);
    end
    end_session();

    // Randomised sessions
    for (int s = 0; s < 25; s++) begin
      or_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      om = $urandom_range(0, 120);
      ep = $urandom_range(100, 255);
      if ($urandom_range(0, 4) == 0) begin
        tmp = om; om = ep; ep = tmp;
      end
      start_session($urandom_range(0, 7), om, ep);
      nb = $urandom_range(1, 30);
      for (int k = 0; k < nb; k++) begin
        send_beat($urandom(), 1'b0, '0, w);
        idle($urandom_range(0, 2));
      end
      end_session();
    end

    // Reset in the middle of a session with a pending output
    or_mode = 2;
    start_session(0, 0, 255);
    send_beat($urandom(), 1'b0, '0, w);
    mon_en = 1'b0;
    areset = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", res_w(), 0);
    chk("mid_rst_hit_count", hit_count, 0);
    chk("mid_rst_round", round, 0);
    chk("mid_rst_stat", stat_hits, 0);
    q.delete();
    @(posedge clk); #1;
    areset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/filter_1.md
# filter_1

Parametrised successor of the pixel window filter. Each accepted beat carries `PIXEL_NUM` pixels; every pixel strictly inside the configured window (`omega` < p < `epsilon`) is replaced by a mode-selected value, and every pixel outside it is zeroed. The block adds valid/ready handshakes on input and output, latches its configuration per session, reports a per-beat hit count, and extends the mode set. It sits in the pixel stream between the frame source and downstream mask/label consumers.

## Interface

Parameters:
- `PIXEL_SIZE`, default 3: log2 of the pixel width; W = 2**PIXEL_SIZE bits.
- `PIXEL_NUM`, default 4: pixels per beat, minimum 1.
- C = $clog2(PIXEL_NUM+1): width of the hit count.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `areset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  starts a session from IDLE.
- `clear`  in  1  ends the session.
- `mode`  in  3  result mode; latched at session start.
- `omega`  in  W  lower window bound (exclusive); latched at session start.
- `epsilon`  in  W  upper window bound (exclusive); latched at session start.
- `pixel[PIXEL_NUM]`  in  W each  input beat.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `result[PIXEL_NUM]`  out  W each  filtered beat.
- `hit_count`  out  C  number of in-window pixels in the `result` beat.
- `round`  out  W  index of the beat currently on `result`.
- `out_valid`  out  1  `result`, `hit_count` and `round` are valid.
- `out_ready`  in  1  downstream accepts the output beat.
- `busy`  out  1  the state is not IDLE.
- `stat_hits`  out  16  accumulated hit total (see Configuration).

## Operation

State machine:
- IDLE: `in_ready`=0. When `enable`=1, latch `mode`/`omega`/`epsilon`, set the round counter R to 0, clear `result`, and go to RUN.
- RUN: `in_ready` = `!clear && (!out_valid || out_ready)`.
  - A beat is accepted when `in_valid && in_ready`. The filtered beat, `hit_count` and `round`=R are registered, `out_valid` is set, and R increments modulo 2**W.
  - When `clear`=1: if `out_valid && !out_ready`, go to DRAIN; otherwise go to IDLE.
- DRAIN: `in_ready`=0. Hold the output until `out_ready`=1, then go to IDLE.
- On reaching IDLE, `out_valid` is 0. `result` holds its last value until the next `enable`.
- `clear` has priority over input acceptance in the same cycle; that input beat is not consumed.
- `enable` is ignored outside IDLE. Changes to `mode`, `omega` or `epsilon` during RUN are ignored.

Per-pixel result i (in-window pixels; out-of-window pixels give 0 except in mode 6):
- Mode 0: all ones.
- Mode 1: R.
- Mode 2: p.
- Mode 3: R*PIXEL_NUM + (PIXEL_NUM-1-i), truncated to W.
- Mode 4: p - omega.
- Mode 5: epsilon - p.
- Mode 6: inverted window. In-window pixels give 0; out-of-window pixels pass p.
- Mode 7: reserved; all results are 0.

Rules:
- All arithmetic is unsigned W-bit with wrap.
- If `omega` >= `epsilon`, the window is empty: no pixel is in-window and `hit_count` is 0.
- `hit_count` always counts in-window pixels, including in modes 6 and 7.

## Timing

- Reset values: `in_ready`, `out_valid`, `busy`=0; `result`, `hit_count`, `round`, `stat_hits`=0; state IDLE; R=0.
- A reset mid-session aborts immediately and drops any pending output.
- IDLE to RUN takes 1 cycle after `enable` is sampled.
- Latency is 1 cycle from accept to `out_valid`.
- Throughput is one beat per cycle while `out_ready`=1.
- With `out_valid`=1 and `out_ready`=0, all outputs are held stable and `in_ready`=0.
- An output transfer and a new accept in the same cycle are legal; the new beat replaces the old one with no bubble.
- R wraps from 2**W-1 to 0 with no flag.

## Configuration

- `FILTER_STAT_EN` defined: `stat_hits` accumulates `hit_count` on every accepted beat and saturates at 16'hFFFF. It is cleared on reset and at session start.
- `FILTER_STAT_EN` undefined: `stat_hits` is tied to 0 and the accumulator is not built.

## Test plan

All scenarios use PIXEL_SIZE=3 and PIXEL_NUM=4.

- Reset, then `enable` with mode 0, omega=10, epsilon=200; send pixels {5,50,199,200} -> after 1 cycle `result`={0,FF,FF,0}, `hit_count`=2, `round`=0.
- Mode 3, three back-to-back beats of {50,50,50,50} with `out_ready`=1 -> beat k gives `result`={4k+3,4k+2,4k+1,4k}; `round`=0,1,2; no bubbles.
- Mode 4, {11,100,9,255} with omega=10, epsilon=200 -> {1,90,0,0}. Mode 6 on the same beat -> {0,0,9,255}, `hit_count`=2.
- Hold `out_ready`=0 for 3 cycles after a beat -> `in_ready`=0 and outputs stable. Raise `clear` in that window -> state is DRAIN and `busy`=1; the next cycle with `out_ready`=1 transfers the beat, then `busy`=0.
- omega=200, epsilon=10, mode 2 -> all results 0 and `hit_count`=0. Changing `mode` during RUN has no effect on results.
- With `FILTER_STAT_EN` defined, 300 beats of four in-window pixels -> `stat_hits`=1200. Assert `areset` mid-stream -> all outputs 0 on the next observed edge.
